mem_arbiter: RTL
================

# mem_arbiter

Three-way arbiter that shares the datapath's single-port, synchronous-read instruction/data memory. The three requesters are the program loader, the data path (LOAD/STORE) and the control unit's instruction fetch. It sits between those requesters and the memory. It serialises accesses with fixed priority plus a fetch anti-starvation override, and returns a one-cycle acknowledge with read data.

## Interface
- AW, 9, memory word-address width
- DW, 16, data word width
- MAX_WAIT, 4, arbitration losses after which fetch overrides all priority (1..15)

- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset (Reset=0 resets)
- {ld,dt,if}_req  in  1 each  access request from loader / data / fetch; held until ack
- {ld,dt,if}_we  in  1 each  1 = write, 0 = read; stable while req=1
- {ld,dt,if}_addr  in  AW each  word address; stable while req=1
- {ld,dt,if}_wdata  in  DW each  write data; stable while req=1
- {ld,dt,if}_ack  out  1 each  one-cycle completion pulse to the owning requester
- rdata  out  DW  read data; valid in the ack cycle
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en
- grant_id  out  2  current owner: 0 ld, 1 dt, 2 if, 3 none
- busy  out  1  1 in ACCESS or RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Arbitration runs in IDLE and in RESP.
  - In RESP the current owner's req is masked, because it is still high during its ack cycle.
- Winner selection:
  - if if_cnt == MAX_WAIT and if_req=1, fetch wins;
  - else ld > dt > if.
- On a win, the winner's we/addr/wdata are registered into mem_we/mem_addr/mem_wdata, grant_id is set to the winner, and the next state is ACCESS.
- If there is no winner: IDLE→IDLE; RESP→IDLE with grant_id=3.
- ACCESS: mem_en=1 for exactly one cycle; next state is RESP.
- RESP:
  - mem_en=0;
  - the owner's ack=1;
  - rdata = mem_rdata (combinational pass-through);
  - on writes, rdata is don't-care but ack is still pulsed.
- rdata outside RESP: holds the last value captured at the end of RESP.
- if_cnt (4-bit fetch wait counter):
  - increments by 1 at each arbitration cycle where if_req=1 and fetch loses;
  - saturates at MAX_WAIT;
  - clears to 0 when fetch is granted or if_req=0.
- Requests arriving in ACCESS are ignored until the next arbitration cycle.
  - A request asserted in ACCESS is arbitrated in the following RESP cycle.
- A requester that re-raises, or continues holding, req after its ack cannot win the RESP arbitration of its own ack cycle.
  - It competes again at the next arbitration.
- Reset (async, any state):
  - state → IDLE;
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - all acks 0, rdata=0, grant_id=3, busy=0, if_cnt=0.
  - An in-flight access is abandoned with no ack; a write issued in the reset cycle is not guaranteed.

## Timing
- Latency from req seen in IDLE at edge N:
  - mem_en high during cycle N+1;
  - ack plus valid rdata during cycle N+2.
- Back-to-back different owners: next mem_en in cycle N+3, so the maximum rate is 1 access / 2 cycles.
- After an idle gap, the minimum is 3 cycles per access.
- Simultaneous req from all three requesters: grant order ld, dt, if (when no override is active).
- mem_addr, mem_we and mem_wdata are stable from ACCESS through RESP.
- Outputs change only on Clock edges, except:
  - asynchronous reset;
  - combinational rdata in RESP.

## Test plan
- Fetch read: mem[0]=16'h0300 (ADD R0,R1,R2), if_req with if_addr=0 at cycle 0 → mem_en=1 with mem_addr=0 in cycle 1; if_ack=1 with rdata=16'h0300 in cycle 2; grant_id=2.
- Data write then read: dt write addr 6, wdata 12 → dt_ack, mem[6]=12; then dt read addr 6 → dt_ack with rdata=12.
- dt_req and if_req asserted together → dt_ack in cycle 2; if mem_en in cycle 3; if_ack in cycle 4; if_cnt returns to 0.
- Starvation, MAX_WAIT=4: ld_req, dt_req and if_req held high → grant sequence ld, dt, ld, dt, if; if_cnt reaches 4 before the fetch grant.
- Loader priority with all three requests raised → acks in order ld, dt, if, each exactly 1 cycle wide.
- Reset=0 asserted mid-ACCESS of a dt read → all outputs take reset values immediately with no dt_ack. After Reset=1 with dt_req still high → full transaction completes with dt_ack 2 cycles after the first IDLE edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// Three-way arbiter for a single-port synchronous-read memory. Fixed priority
// ld > dt > if, with an override that lets a starved fetch win after MAX_WAIT losses.
module mem_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ld_req_i,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_wdata_i,
    input  logic          dt_req_i,
    input  logic          dt_we_i,
    input  logic [AW-1:0] dt_addr_i,
    input  logic [DW-1:0] dt_wdata_i,
    input  logic          if_req_i,
    input  logic          if_we_i,
    input  logic [AW-1:0] if_addr_i,
    input  logic [DW-1:0] if_wdata_i,
    output logic          ld_ack_o,
    output logic          dt_ack_o,
    output logic          if_ack_o,
    output logic [DW-1:0] rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [1:0]    grant_id_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [1:0] GNT_LD   = 2'd0;
    localparam logic [1:0] GNT_DT   = 2'd1;
    localparam logic [1:0] GNT_IF   = 2'd2;
    localparam logic [1:0] GNT_NONE = 2'd3;
    localparam logic [3:0] MAX_CNT  = 4'(MAX_WAIT);

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          memWe_q, memWe_d;
    logic [AW-1:0] memAddr_q, memAddr_d;
    logic [DW-1:0] memWdata_q, memWdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [3:0]    ifCnt_q, ifCnt_d;

    logic          ldReq, dtReq, ifReq;
    logic [1:0]    winner;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= GNT_NONE;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            rdata_q    <= '0;
            ifCnt_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            rdata_q    <= rdata_d;
            ifCnt_q    <= ifCnt_d;
        end
    end

    // The owner still holds req during its ack cycle, so it is masked out of the RESP arbitration.
    always_comb begin
        ldReq = ld_req_i && !(state_q == RESP && grant_q == GNT_LD);
        dtReq = dt_req_i && !(state_q == RESP && grant_q == GNT_DT);
        ifReq = if_req_i && !(state_q == RESP && grant_q == GNT_IF);

        if (ifReq && ifCnt_q == MAX_CNT) winner = GNT_IF;
        else if (ldReq)                  winner = GNT_LD;
        else if (dtReq)                  winner = GNT_DT;
        else if (ifReq)                  winner = GNT_IF;
        else                             winner = GNT_NONE;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        rdata_d    = rdata_q;
        ifCnt_d    = ifCnt_q;

        case (state_q)
            IDLE, RESP: begin
                if (state_q == RESP) rdata_d = mem_rdata_i;

                if (!ifReq || winner == GNT_IF) ifCnt_d = 4'd0;
                else if (ifCnt_q < MAX_CNT)     ifCnt_d = ifCnt_q + 4'd1;

                grant_d = winner;
                case (winner)
                    GNT_LD: begin
                        state_d    = ACCESS;
                        memWe_d    = ld_we_i;
                        memAddr_d  = ld_addr_i;
                        memWdata_d = ld_wdata_i;
                    end
                    GNT_DT: begin
                        state_d    = ACCESS;
                        memWe_d    = dt_we_i;
                        memAddr_d  = dt_addr_i;
                        memWdata_d = dt_wdata_i;
                    end
                    GNT_IF: begin
                        state_d    = ACCESS;
                        memWe_d    = if_we_i;
                        memAddr_d  = if_addr_i;
                        memWdata_d = if_wdata_i;
                    end
                    default: state_d = IDLE;
                endcase
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    assign mem_en_o    = (state_q == ACCESS);
    assign mem_we_o    = memWe_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;
    assign grant_id_o  = grant_q;
    assign busy_o      = (state_q != IDLE);
    assign ld_ack_o    = (state_q == RESP) && (grant_q == GNT_LD);
    assign dt_ack_o    = (state_q == RESP) && (grant_q == GNT_DT);
    assign if_ack_o    = (state_q == RESP) && (grant_q == GNT_IF);
    // Read data passes straight through in the ack cycle and is held afterwards.
    assign rdata_o     = (state_q == RESP) ? mem_rdata_i : rdata_q;

endmodule
